axis_pkt_checker: RTL and testbench

AXIS_PKT_CHECKER -- requirements
Module: axis_pkt_checker

---
 rtl/axis_pkt_checker.sv | 94 +++++++++
 tb/tb_axis_pkt_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_checker.sv
// AXI-Stream packet checker: verifies 0..PACKET_SIZE-1 beat sequence and tlast position.
// Optional macro AXIS_CHK_BACKPRESSURE_EN gates s_tready with an 8-bit LFSR.
module axis_pkt_checker #(
  parameter int DATA_WIDTH  = 8,
  parameter int PACKET_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count,
  output logic                  seq_err,
  output logic                  last_err,
  output logic                  busy
);

  localparam int EW = $clog2(PACKET_SIZE);
  localparam logic [EW-1:0] EXP_LAST = EW'(PACKET_SIZE - 1);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          rdy_q, rdy_d;
  logic          acc, at_last, seq_bad, last_bad;

  always_comb begin
    acc      = s_tvalid & rdy_q;
    at_last  = (exp_q == EXP_LAST);
    seq_bad  = {{EW{1'b0}}, s_tdata} != {{DATA_WIDTH{1'b0}}, exp_q};
    last_bad = (s_tlast != at_last);
    exp_d    = exp_q;
    state_d  = state_q;
    if (acc) begin
      // Missing tlast at the final beat restarts the sequence from zero.
      if (s_tlast || at_last) begin
        exp_d   = '0;
        state_d = IDLE;
      end else begin
        state_d = IN_PKT;
        if (seq_bad) exp_d = EW'(s_tdata) + EW'(1);
        else         exp_d = exp_q + EW'(1);
      end
    end
  end

`ifdef AXIS_CHK_BACKPRESSURE_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rdy_d  = lfsr_d[1] | lfsr_d[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 8'hA5;
    else          lfsr_q <= lfsr_d;
  end
`else
  always_comb rdy_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      rdy_q     <= 1'b0;
      pkt_count <= '0;
      err_count <= '0;
      seq_err   <= 1'b0;
      last_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      rdy_q    <= rdy_d;
      seq_err  <= acc & seq_bad;
      last_err <= acc & last_bad;
      if (acc && s_tlast)
        pkt_count <= pkt_count + 16'd1;
      if (acc && (seq_bad || last_bad) && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

  assign s_tready = rdy_q;
  assign busy     = (state_q == IN_PKT);

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed testbench for axis_pkt_checker.
// Works with or without AXIS_CHK_BACKPRESSURE_EN defined.
module tb_axis_pkt_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic        seq_err;
  logic        last_err;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   n_seq = 0;
  int   n_last = 0;
  logic saw_low = 1'b0;

  axis_pkt_checker #(
    .DATA_WIDTH (8),
    .PACKET_SIZE(16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .pkt_count(pkt_count),
    .err_count(err_count),
    .seq_err  (seq_err),
    .last_err (last_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (seq_err)  n_seq  <= n_seq + 1;
    if (last_err) n_last <= n_last + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #1;
    chk("rst_rdy",  s_tready,  0);
    chk("rst_pkt",  pkt_count, 0);
    chk("rst_err",  err_count, 0);
    chk("rst_seq",  seq_err,   0);
    chk("rst_last", last_err,  0);
    chk("rst_busy", busy,      0);
    idle(2);
    reset_n = 1'b1;
    #1;
    chk("rdy_pre", s_tready, 0);
    @(negedge clk);
    chk("rdy_post", s_tready, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int   n = 0;
    logic r;
    logic done = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!done && n < 100) begin
      r = s_tready;
      if (!r) saw_low = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (r) done = 1'b1;
      n++;
    end
    if (!done) chk("accept_timeout", 0, 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pkt(input int lo, input int hi, input logic with_last);
    for (int i = lo; i <= hi; i++)
      send(8'(i), with_last && (i == hi));
  endtask

  int s0, l0;

  initial begin
    // two clean packets
    do_reset();
    s0 = n_seq; l0 = n_last;
    send(8'd0, 1'b0);
    chk("busy_mid", busy, 1);
    pkt(1, 15, 1'b1);
    chk("busy_end", busy, 0);
    pkt(0, 15, 1'b1);
    idle(2);
    chk("clean_pkt", pkt_count, 2);
    chk("clean_err", err_count, 0);
    chk("clean_seqp", n_seq - s0, 0);
    chk("clean_lastp", n_last - l0, 0);
    // tdata/tlast ignored without tvalid
    s_tdata = 8'h55; s_tlast = 1'b1;
    idle(3);
    s_tlast = 1'b0;
    chk("ign_pkt", pkt_count, 2);
    chk("ign_err", err_count, 0);

    // wrong data on beat 5, resync
    do_reset();
    s0 = n_seq; l0 = n_last;
    pkt(0, 4, 1'b0);
    send(8'h09, 1'b0);
    chk("seq_pulse", seq_err, 1);
    chk("seq_nolast", last_err, 0);
    chk("seq_errcnt", err_count, 1);
    send(8'd10, 1'b0);
    chk("seq_drop", seq_err, 0);
    pkt(11, 15, 1'b1);
    idle(2);
    chk("seq_pkt", pkt_count, 1);
    chk("seq_err_f", err_count, 1);
    chk("seq_np", n_seq - s0, 1);
    chk("seq_nl", n_last - l0, 0);

    // early tlast then clean packet
    do_reset();
    s0 = n_seq; l0 = n_last;
    pkt(0, 7, 1'b1);
    chk("early_last", last_err, 1);
    chk("early_noseq", seq_err, 0);
    chk("early_busy", busy, 0);
    chk("early_pkt1", pkt_count, 1);
    pkt(0, 15, 1'b1);
    idle(2);
    chk("early_pkt", pkt_count, 2);
    chk("early_err", err_count, 1);
    chk("early_nl", n_last - l0, 1);
    chk("early_ns", n_seq - s0, 0);

    // missing tlast then clean packet
    do_reset();
    s0 = n_seq; l0 = n_last;
    pkt(0, 15, 1'b0);
    chk("miss_last", last_err, 1);
    chk("miss_busy", busy, 0);
    chk("miss_pkt0", pkt_count, 0);
    pkt(0, 15, 1'b1);
    idle(2);
    chk("miss_pkt", pkt_count, 1);
    chk("miss_err", err_count, 1);
    chk("miss_nl", n_last - l0, 1);
    chk("miss_ns", n_seq - s0, 0);

    // both errors on one beat, back-to-back bad beats
    do_reset();
    s0 = n_seq; l0 = n_last;
    send(8'd3, 1'b1);
    chk("both_seq", seq_err, 1);
    chk("both_last", last_err, 1);
    chk("both_err", err_count, 1);
    chk("both_pkt", pkt_count, 1);
    send(8'd5, 1'b0);
    chk("b2b_seq1", seq_err, 1);
    chk("b2b_last1", last_err, 0);
    send(8'd9, 1'b0);
    chk("b2b_seq2", seq_err, 1);
    chk("b2b_err", err_count, 3);
    idle(2);
    chk("b2b_ns", n_seq - s0, 3);
    chk("b2b_nl", n_last - l0, 1);

    // reset mid-packet discards it
    do_reset();
    pkt(0, 8, 1'b0);
    chk("mid_busy", busy, 1);
    do_reset();
    s0 = n_seq; l0 = n_last;
    pkt(0, 15, 1'b1);
    idle(2);
    chk("mid_pkt", pkt_count, 1);
    chk("mid_err", err_count, 0);
    chk("mid_np", (n_seq - s0) + (n_last - l0), 0);

    // 100 clean packets, stalls only with backpressure
    do_reset();
    s0 = n_seq; l0 = n_last;
    saw_low = 1'b0;
    for (int p = 0; p < 100; p++) pkt(0, 15, 1'b1);
    idle(2);
    chk("bulk_pkt", pkt_count, 100);
    chk("bulk_err", err_count, 0);
    chk("bulk_np", (n_seq - s0) + (n_last - l0), 0);
`ifdef AXIS_CHK_BACKPRESSURE_EN
    chk("bulk_stall", saw_low, 1);
`else
    chk("bulk_nostall", saw_low, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
